// File: rtl/proc_test_sequencer.sv
// Multi-program self-check sequencer for the single-cycle core: resets, runs, settles and scores each program.
// Optional cycle_total port and RUN/SETTLE cycle counter enabled by defining PROC_TEST_CYCLE_COUNT_EN.
module proc_test_sequencer #(
  parameter int NUM_PROGS     = 4,
  parameter int PC_W          = 64,
  parameter int DATA_W        = 64,
  parameter int WDOG_W        = 16,
  parameter int WDOG_LIMIT    = 255,
  parameter int RST_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 1,
  localparam int IDX_W        = $clog2(NUM_PROGS) + 1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_PROGS*PC_W-1:0]   startpc_tbl,
  input  logic [NUM_PROGS*PC_W-1:0]   endpc_tbl,
  input  logic [NUM_PROGS*DATA_W-1:0] expect_tbl,
  input  logic [PC_W-1:0]             currentpc,
  input  logic [DATA_W-1:0]           dmemout,
  output logic                        proc_resetl,
  output logic [PC_W-1:0]             proc_startpc,
  output logic [IDX_W-1:0]            prog_idx,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  pass_count,
  output logic [NUM_PROGS-1:0]        fail_mask,
`ifdef PROC_TEST_CYCLE_COUNT_EN
  output logic [NUM_PROGS-1:0]        timeout_mask,
  output logic [31:0]                 cycle_total
`else
  output logic [NUM_PROGS-1:0]        timeout_mask
`endif
);

  // state  | meaning
  // IDLE   | core held in reset, waiting for start     HOLD   | core in reset, start PC driven
  // RUN    | core running, watchdog counting           SETTLE | end PC seen, waiting before sample
  // CHECK  | compare dmemout with expected code        NEXT   | core back in reset, advance index
  // DONE   | results valid, start restarts the sequence
  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_SETTLE, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam int TBL_N  = 2 ** IDX_W;
  localparam int HCNT_W = $clog2(RST_CYCLES + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_PROGS - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(RST_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST   = WDOG_W'(WDOG_LIMIT - 1);

  state_t                state_q, state_d;
  logic                  proc_resetl_q, proc_resetl_d;
  logic [PC_W-1:0]       proc_startpc_q, proc_startpc_d;
  logic [IDX_W-1:0]      prog_idx_q, prog_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            pass_count_q, pass_count_d;
  logic [NUM_PROGS-1:0]  fail_mask_q, fail_mask_d;
  logic [NUM_PROGS-1:0]  timeout_mask_q, timeout_mask_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [HCNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [SCNT_W-1:0]     settle_cnt_q, settle_cnt_d;
`ifdef PROC_TEST_CYCLE_COUNT_EN
  logic [31:0]           cycle_total_q, cycle_total_d;
`endif

  // Tables padded to a power of two so prog_idx indexes them at its full width.
  logic [PC_W-1:0]   start_arr [TBL_N];
  logic [PC_W-1:0]   end_arr   [TBL_N];
  logic [DATA_W-1:0] exp_arr   [TBL_N];

  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    if (g < NUM_PROGS) begin : g_used
      assign start_arr[g] = startpc_tbl[g*PC_W +: PC_W];
      assign end_arr[g]   = endpc_tbl[g*PC_W +: PC_W];
      assign exp_arr[g]   = expect_tbl[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign start_arr[g] = '0;
      assign end_arr[g]   = '0;
      assign exp_arr[g]   = '0;
    end
  end

  logic [NUM_PROGS-1:0] idx_oh;
  logic [IDX_W-1:0]     idx_inc;

  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      idx_oh[i] = (prog_idx_q == IDX_W'(i));
    end
    idx_inc = prog_idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    proc_resetl_d  = proc_resetl_q;
    proc_startpc_d = proc_startpc_q;
    prog_idx_d     = prog_idx_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_count_d   = pass_count_q;
    fail_mask_d    = fail_mask_q;
    timeout_mask_d = timeout_mask_q;
    wdog_d         = wdog_q;
    hold_cnt_d     = hold_cnt_q;
    settle_cnt_d   = settle_cnt_q;
`ifdef PROC_TEST_CYCLE_COUNT_EN
    cycle_total_d  = cycle_total_q;
    if ((state_q == S_RUN || state_q == S_SETTLE) && cycle_total_q != 32'hFFFF_FFFF) begin
      cycle_total_d = cycle_total_q + 32'd1;
    end
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        proc_resetl_d = 1'b0;
        if (start) begin
          state_d        = S_HOLD;
          prog_idx_d     = '0;
          pass_count_d   = '0;
          fail_mask_d    = '0;
          timeout_mask_d = '0;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          hold_cnt_d     = '0;
          proc_startpc_d = start_arr[0];
`ifdef PROC_TEST_CYCLE_COUNT_EN
          cycle_total_d  = '0;
`endif
        end
      end
      S_HOLD: begin
        proc_resetl_d  = 1'b0;
        proc_startpc_d = start_arr[prog_idx_q];
        if (hold_cnt_q == HOLD_LAST) begin
          state_d       = S_RUN;
          proc_resetl_d = 1'b1;
          wdog_d        = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HCNT_W'(1);
        end
      end
      S_RUN: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // End-PC detection takes priority over a watchdog expiring in the same cycle.
        if (currentpc >= end_arr[prog_idx_q]) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d        = S_NEXT;
          proc_resetl_d  = 1'b0;
          timeout_mask_d = timeout_mask_q | idx_oh;
          fail_mask_d    = fail_mask_q | idx_oh;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + SCNT_W'(1);
        end
      end
      S_CHECK: begin
        state_d       = S_NEXT;
        proc_resetl_d = 1'b0;
        if (dmemout == exp_arr[prog_idx_q]) begin
          pass_count_d = (pass_count_q == 8'hFF) ? pass_count_q : pass_count_q + 8'd1;
        end else begin
          fail_mask_d = fail_mask_q | idx_oh;
        end
      end
      S_NEXT: begin
        proc_resetl_d = 1'b0;
        if (prog_idx_q == IDX_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d        = S_HOLD;
          prog_idx_d     = idx_inc;
          proc_startpc_d = start_arr[idx_inc];
          hold_cnt_d     = '0;
        end
      end
      default: begin
        state_d       = S_IDLE;
        proc_resetl_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q        <= S_IDLE;
      proc_resetl_q  <= 1'b0;
      proc_startpc_q <= '0;
      prog_idx_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_count_q   <= '0;
      fail_mask_q    <= '0;
      timeout_mask_q <= '0;
      wdog_q         <= '0;
      hold_cnt_q     <= '0;
      settle_cnt_q   <= '0;
`ifdef PROC_TEST_CYCLE_COUNT_EN
      cycle_total_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      proc_resetl_q  <= proc_resetl_d;
      proc_startpc_q <= proc_startpc_d;
      prog_idx_q     <= prog_idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_count_q   <= pass_count_d;
      fail_mask_q    <= fail_mask_d;
      timeout_mask_q <= timeout_mask_d;
      wdog_q         <= wdog_d;
      hold_cnt_q     <= hold_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
`ifdef PROC_TEST_CYCLE_COUNT_EN
      cycle_total_q  <= cycle_total_d;
`endif
    end
  end

  assign proc_resetl  = proc_resetl_q;
  assign proc_startpc = proc_startpc_q;
  assign prog_idx     = prog_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_count   = pass_count_q;
  assign fail_mask    = fail_mask_q;
  assign timeout_mask = timeout_mask_q;
`ifdef PROC_TEST_CYCLE_COUNT_EN
  assign cycle_total  = cycle_total_q;
`endif

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Bench for proc_test_sequencer: a 4-program instance checked every cycle against a schedule model,
// plus a 1-program instance checked with hand-computed results. Honours PROC_TEST_CYCLE_COUNT_EN.
module tb_proc_test_sequencer;
  localparam int NP   = 4;
  localparam int LIM  = 16;
  localparam int RSTC = 2;
  localparam int SETC = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset, start, start1;
  int   total = 0;
  int   bad   = 0;

  // ---------------- 4-program instance ----------------
  logic [63:0] st [NP];
  logic [63:0] en [NP];
  logic [63:0] code [NP];
  logic [63:0] ex [NP];
  logic [NP*64-1:0] startpc_tbl, endpc_tbl, expect_tbl;
  logic [63:0] pc = '0;
  logic [63:0] dmemout;
  logic        proc_resetl, busy, done;
  logic [63:0] proc_startpc;
  logic [2:0]  prog_idx;
  logic [7:0]  pass_count;
  logic [3:0]  fail_mask, timeout_mask;
  logic [31:0] cycle_total;

  always_comb begin
    startpc_tbl = '0;
    endpc_tbl   = '0;
    expect_tbl  = '0;
    for (int i = 0; i < NP; i++) begin
      startpc_tbl[i*64 +: 64] = st[i];
      endpc_tbl[i*64 +: 64]   = en[i];
      expect_tbl[i*64 +: 64]  = ex[i];
    end
  end

  // Core stand-in: PC loads the start PC while in reset, then steps by 4 each cycle.
  always_ff @(posedge CLK) pc <= proc_resetl ? pc + 64'd4 : proc_startpc;
  assign dmemout = (pc >= en[prog_idx[1:0]]) ? code[prog_idx[1:0]] : 64'h0;

  proc_test_sequencer #(
    .NUM_PROGS(NP), .PC_W(64), .DATA_W(64), .WDOG_W(16),
    .WDOG_LIMIT(LIM), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC)
  ) u_dut (
    .CLK(CLK), .reset(reset), .start(start),
    .startpc_tbl(startpc_tbl), .endpc_tbl(endpc_tbl), .expect_tbl(expect_tbl),
    .currentpc(pc), .dmemout(dmemout),
    .proc_resetl(proc_resetl), .proc_startpc(proc_startpc), .prog_idx(prog_idx),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_mask(fail_mask),
`ifdef PROC_TEST_CYCLE_COUNT_EN
    .timeout_mask(timeout_mask), .cycle_total(cycle_total)
`else
    .timeout_mask(timeout_mask)
`endif
  );
`ifndef PROC_TEST_CYCLE_COUNT_EN
  assign cycle_total = '0;
`endif

  // ---------------- 1-program instance (defaults) ----------------
  logic [63:0] pc1 = '0;
  logic [63:0] dmem1, startpc1;
  logic        resetl1, busy1, done1;
  logic [0:0]  idx1, fail1, tmo1;
  logic [7:0]  pass1;
  logic [31:0] cyc1;

  always_ff @(posedge CLK) pc1 <= resetl1 ? pc1 + 64'd4 : startpc1;
  assign dmem1 = (pc1 >= 64'h34) ? 64'hF : 64'h0;

  proc_test_sequencer #(.NUM_PROGS(1)) u_dut1 (
    .CLK(CLK), .reset(reset), .start(start1),
    .startpc_tbl(64'h0), .endpc_tbl(64'h34), .expect_tbl(64'hF),
    .currentpc(pc1), .dmemout(dmem1),
    .proc_resetl(resetl1), .proc_startpc(startpc1), .prog_idx(idx1),
    .busy(busy1), .done(done1), .pass_count(pass1), .fail_mask(fail1),
`ifdef PROC_TEST_CYCLE_COUNT_EN
    .timeout_mask(tmo1), .cycle_total(cyc1)
`else
    .timeout_mask(tmo1)
`endif
  );
`ifndef PROC_TEST_CYCLE_COUNT_EN
  assign cyc1 = '0;
`endif

  // ---------------- schedule model ----------------
  typedef struct packed {
    logic        rl;
    logic [63:0] spc;
    logic [2:0]  idx;
    logic        busy;
    logic        done;
    logic [7:0]  pass;
    logic [3:0]  fail;
    logic [3:0]  tmo;
    logic [31:0] cyc;
  } rec_t;

  rec_t        exp_q [$];
  rec_t        rest;
  rec_t        cur;
  logic [7:0]  m_pass;
  logic [3:0]  m_fail, m_tmo;
  logic [31:0] m_cyc;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input logic rl, input int i, input bit in_run);
    rec_t r;
    r.rl = rl; r.spc = st[i]; r.idx = 3'(i); r.busy = 1'b1; r.done = 1'b0;
    r.pass = m_pass; r.fail = m_fail; r.tmo = m_tmo; r.cyc = m_cyc;
    exp_q.push_back(r);
    if (in_run) m_cyc++;
  endtask

  // Each program: RSTC cycles in reset, then its run length (PC steps by 4 from the start PC),
  // then settle + check, or straight to the next program on timeout; one reset cycle between programs.
  task automatic build_seq();
    longint unsigned k;
    int run;
    bit timed;
    exp_q.delete();
    m_pass = '0; m_fail = '0; m_tmo = '0; m_cyc = '0;
    for (int i = 0; i < NP; i++) begin
      k = (en[i] > st[i]) ? (en[i] - st[i] + 64'd3) / 64'd4 : 64'd0;
      timed = (k >= longint'(LIM));
      run = timed ? LIM : int'(k) + 1;
      repeat (RSTC) push(1'b0, i, 1'b0);
      repeat (run) push(1'b1, i, 1'b1);
      if (timed) begin
        m_tmo[i] = 1'b1;
        m_fail[i] = 1'b1;
      end else begin
        repeat (SETC) push(1'b1, i, 1'b1);
        push(1'b1, i, 1'b0);
        if (code[i] == ex[i]) m_pass++;
        else m_fail[i] = 1'b1;
      end
      push(1'b0, i, 1'b0);
    end
    rest.rl = 1'b0; rest.spc = st[NP-1]; rest.idx = 3'(NP-1); rest.busy = 1'b0; rest.done = 1'b1;
    rest.pass = m_pass; rest.fail = m_fail; rest.tmo = m_tmo; rest.cyc = m_cyc;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : rest;
      chk("proc_resetl", proc_resetl, cur.rl);
      chk("proc_startpc", proc_startpc, cur.spc);
      chk("prog_idx", prog_idx, cur.idx);
      chk("busy", busy, cur.busy);
      chk("done", done, cur.done);
      chk("pass_count", pass_count, cur.pass);
      chk("fail_mask", fail_mask, cur.fail);
      chk("timeout_mask", timeout_mask, cur.tmo);
`ifdef PROC_TEST_CYCLE_COUNT_EN
      chk("cycle_total", cycle_total, cur.cyc);
`endif
    end
  end

  task automatic do_start();
    @(negedge CLK); #1;
    build_seq();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_seq();
    for (int c = 0; c < 1000 && exp_q.size() > 0; c++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL wait_seq: %0d schedule entries left, expected 0", exp_q.size());
    end
    @(negedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int rise4, rise1, done1_at, done4_at;
    bit hit;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    rest = '0;
    st[0] = 64'h000; en[0] = 64'h030;               code[0] = 64'hF; ex[0] = 64'hF;
    st[1] = 64'h100; en[1] = 64'hFFFF_FFFF_0000_0000; code[1] = 64'hF; ex[1] = 64'hF;
    st[2] = 64'h200; en[2] = 64'h210;               code[2] = 64'hE; ex[2] = 64'hF;
    st[3] = 64'h300; en[3] = 64'h33C;               code[3] = 64'hF; ex[3] = 64'hF;
    repeat (3) @(negedge CLK);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_resetl", proc_resetl, 1'b0);
    chk("reset_busy1", busy1, 1'b0);

    // Sequence A: pass, timeout, mismatch, end PC on the watchdog's last cycle.
    @(negedge CLK); #1;
    build_seq();
    chk("model_len_A", exp_q.size(), 68);
    start = 1'b1; start1 = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; start1 = 1'b0;
    rise4 = 0; rise1 = 0; done1_at = 0; done4_at = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK); #1;
      if (proc_resetl && rise4 == 0) rise4 = c;
      if (resetl1 && rise1 == 0) rise1 = c;
      if (done1 && done1_at == 0) done1_at = c;
      if (done && done4_at == 0) done4_at = c;
    end
    chk("A_first_run_cycle", rise4, RSTC + 1);
    chk("A_done_cycle", done4_at, 69);
    chk("A_pass_count", pass_count, 8'd2);
    chk("A_fail_mask", fail_mask, 4'b0110);
    chk("A_timeout_mask", timeout_mask, 4'b0010);
    chk("A_invariant", pass_count + $countones(fail_mask), NP);
    chk("one_first_run_cycle", rise1, 2);
    chk("one_done_cycle", done1_at, 19);
    chk("one_done", done1, 1'b1);
    chk("one_pass_count", pass1, 8'd1);
    chk("one_fail_mask", fail1, 1'b0);
    chk("one_timeout_mask", tmo1, 1'b0);
`ifdef PROC_TEST_CYCLE_COUNT_EN
    chk("A_cycle_total", cycle_total, 32'd53);
    chk("one_cycle_total", cyc1, 32'd15);
`endif

    // Sequence B from DONE: immediate end PC, spurious start while busy, one mismatch.
    en[0] = 64'h000; en[1] = 64'h120;
    do_start();
    repeat (10) @(negedge CLK);
    #1;
    chk("B_busy_at_extra_start", busy, 1'b1);
    start = 1'b1;
    @(negedge CLK); #1;
    start = 1'b0;
    wait_seq();
    chk("B_done", done, 1'b1);
    chk("B_pass_count", pass_count, 8'd3);
    chk("B_fail_mask", fail_mask, 4'b0100);
    chk("B_timeout_mask", timeout_mask, 4'b0000);

    // Sequence C: reset during RUN of program 2, then a clean rerun.
    do_start();
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge CLK); #1;
      if (prog_idx == 3'd2 && proc_resetl) hit = 1'b1;
    end
    chk("C_reached_prog2_run", hit, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    rest = '0;
    @(negedge CLK); #1;
    reset = 1'b0;
    chk("C_abort_resetl", proc_resetl, 1'b0);
    chk("C_abort_busy", busy, 1'b0);
    chk("C_abort_fail_mask", fail_mask, 4'b0000);
    do_start();
    wait_seq();
    chk("C_pass_count", pass_count, 8'd3);
    chk("C_fail_mask", fail_mask, 4'b0100);
    chk("C_timeout_mask", timeout_mask, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/proc_test_sequencer.md
Name: proc_test_sequencer

Overview:
- Synthesizable, multi-program successor to the single-cycle processor self-check harness.
- Sits beside the singlecycle core on FPGA or in regression.
- For each of NUM_PROGS programs it:
  - holds the core in reset and drives its start PC;
  - runs the core until currentpc reaches that program's end PC;
  - waits a settle window, then compares dmemout with the expected pass code;
  - guards every program with a per-program watchdog.
- Reports a pass count, a per-program fail mask and a timeout mask.

Parameters:
- NUM_PROGS, 4, number of programs in the table (1..16)
- PC_W, 64, PC width
- DATA_W, 64, dmemout and expected-code width
- WDOG_W, 16, watchdog counter width
- WDOG_LIMIT, 255, run cycles allowed per program before timeout
- RST_CYCLES, 1, cycles proc_resetl is held low per program (>=1)
- SETTLE_CYCLES, 1, cycles after end PC before sampling dmemout (>=1)

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence when idle
- startpc_tbl  in  NUM_PROGS*PC_W  start PCs; program i occupies bits [i*PC_W +: PC_W]
- endpc_tbl  in  NUM_PROGS*PC_W  end PCs, same packing
- expect_tbl  in  NUM_PROGS*DATA_W  expected pass codes, same packing
- currentpc  in  PC_W  from core
- dmemout  in  DATA_W  from core
- proc_resetl  out  1  active-low reset to core
- proc_startpc  out  PC_W  start PC to core
- prog_idx  out  $clog2(NUM_PROGS)+1  index of the program under test
- busy  out  1  sequence in progress
- done  out  1  high from sequence end until next start or reset
- pass_count  out  8  programs passed
- fail_mask  out  NUM_PROGS  bit i set if program i failed (mismatch or timeout)
- timeout_mask  out  NUM_PROGS  bit i set if program i timed out

Behaviour:
- Reset values:
  - state IDLE, proc_resetl=0, proc_startpc=0, prog_idx=0;
  - busy=0, done=0, pass_count=0, fail_mask=0, timeout_mask=0;
  - watchdog and settle counters 0.
- Reset mid-sequence aborts immediately to these values. The core stays held in reset.
- States: IDLE, HOLD, RUN, SETTLE, CHECK, NEXT, DONE.
- IDLE:
  - proc_resetl=0.
  - start=1 -> HOLD: prog_idx=0, counts and masks cleared, busy=1, done=0.
- HOLD:
  - proc_resetl=0; proc_startpc=startpc_tbl[prog_idx].
  - After RST_CYCLES cycles -> RUN. proc_resetl goes 1 in the same edge; watchdog=0.
- RUN:
  - watchdog increments each cycle.
  - Unsigned currentpc >= endpc_tbl[prog_idx] -> SETTLE, settle counter=0.
  - Otherwise, watchdog == WDOG_LIMIT-1 -> NEXT with timeout_mask[i]=1 and fail_mask[i]=1.
  - If both hold in the same cycle, end-PC detection wins.
- SETTLE: counts SETTLE_CYCLES cycles; the core keeps running; -> CHECK.
- CHECK (one cycle):
  - dmemout == expect_tbl[prog_idx] -> pass_count+1.
  - Otherwise fail_mask[i]=1.
  - -> NEXT.
- NEXT:
  - proc_resetl=0.
  - prog_idx==NUM_PROGS-1 -> DONE.
  - Otherwise prog_idx+1 -> HOLD.
- DONE: busy=0, done=1, proc_resetl=0.
  - start=1 restarts as from IDLE (masks and counts cleared).
  - Otherwise stays in DONE.
- start outside IDLE/DONE is ignored.
- Table inputs are sampled live. They must be stable while busy=1.
- pass_count saturates at 255.
- Invariant: pass_count + popcount(fail_mask) == NUM_PROGS when done=1.
- Latency for program i: RST_CYCLES + run cycles + SETTLE_CYCLES + 2 (CHECK, NEXT).

Optional Feature:
- Macro: PROC_TEST_CYCLE_COUNT_EN.
- Defined:
  - adds output port cycle_total (32 bits, reset 0);
  - counts every cycle spent in RUN and SETTLE across the whole sequence;
  - cleared on start;
  - saturates at 0xFFFFFFFF.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- NUM_PROGS=1, startpc 0x0, endpc 0x34, expect 0xF.
  - Core model steps PC by 4 per cycle and drives dmemout=0xF after end.
  - -> done=1, pass_count=1, fail_mask=0, timeout_mask=0. proc_resetl was low exactly RST_CYCLES cycles before RUN.
- NUM_PROGS=4, program 2 expect mismatched (dmemout 0xE vs 0xF).
  - -> pass_count=3, fail_mask=4'b0100, timeout_mask=0.
- Program 1 PC never reaches end, WDOG_LIMIT=16.
  - -> RUN exits after 16 cycles, timeout_mask=4'b0010, fail_mask=4'b0010. Sequence continues to programs 2,3.
- End PC reached on the same cycle the watchdog expires.
  - -> treated as reached; program checked, no timeout bit.
- reset asserted during RUN of program 2.
  - -> next cycle all outputs at reset values, proc_resetl=0.
  - A following start reruns from program 0 with clean masks.
- start pulse while busy=1.
  - -> ignored, prog_idx sequence unchanged.
- With PROC_TEST_CYCLE_COUNT_EN, program 0 with 13 run cycles and SETTLE_CYCLES=1.
  - -> cycle_total=14.
